// File: rtl/multicycle_cla_adder_pkg.sv
// Shared types and sizing helpers for the multicycle carry-lookahead adder.
package multicycle_cla_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // A single-slice configuration still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multicycle_cla_adder_if.sv
// Operand/result handshake bundle between the source, the adder and the consumer.
interface multicycle_cla_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/multicycle_cla_adder_cla.sv
// N-bit carry-lookahead adder; each carry is a flat generate/propagate sum of products.
module CarryLookAhead_Adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N-1:0] g_s;
  logic [N-1:0] p_s;
  logic [N:0]   c_s;
  logic         acc_s;
  logic         prop_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin, built without chaining c[i]
  always_comb begin
    c_s    = {(N+1){1'b0}};
    acc_s  = 1'b0;
    prop_s = 1'b0;
    c_s[0] = cin;
    for (int i = 0; i < N; i++) begin
      acc_s  = g_s[i];
      prop_s = p_s[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc_s  = acc_s | (prop_s & g_s[j]);
        prop_s = prop_s & p_s[j];
      end
      c_s[i+1] = acc_s | (prop_s & cin);
    end
  end

  assign sum  = p_s ^ c_s[N-1:0];
  assign cout = c_s[N];
endmodule

// File: rtl/multicycle_cla_adder.sv
// Wide adder that pushes SLICE bits per cycle through one lookahead slice, carrying between cycles.
module multicycle_cla_adder
  import multicycle_cla_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_cla_adder_if.slave bus
);
  localparam int NSL = nslice(WIDTH, SLICE);
  localparam int CW  = cnt_width(NSL);
  localparam logic [CW-1:0] LAST_CNT = CW'(NSL - 1);

  if ((WIDTH % SLICE) != 0) begin : g_width_check
    $error("WIDTH must be an integer multiple of SLICE");
  end

  state_t                 state_r;
  logic [WIDTH-1:0]       a_r;
  logic [WIDTH-1:0]       b_r;
  logic [WIDTH-1:0]       sum_r;
  logic                   carry_r;
  logic                   a_msb_r;
  logic                   b_msb_r;
  logic [CW-1:0]          cnt_r;
  logic                   cout_r;
  logic                   ovf_r;
  logic                   out_valid_r;
  logic [SLICE-1:0]       slice_sum_s;
  logic                   slice_cout_s;
  logic [WIDTH+SLICE-1:0] sum_shift_s;

  CarryLookAhead_Adder #(.N(SLICE)) u_slice (
    .a    (a_r[SLICE-1:0]),
    .b    (b_r[SLICE-1:0]),
    .cin  (carry_r),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // New slice enters at the top; after NSL cycles the first slice sits at bit 0.
  assign sum_shift_s = {slice_sum_s, sum_r} >> SLICE;

  // Sequencer: accept operands, step one slice per cycle, hold the result until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      a_msb_r     <= 1'b0;
      b_msb_r     <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            carry_r <= bus.cin;
            a_msb_r <= bus.a[WIDTH-1];
            b_msb_r <= bus.b[WIDTH-1];
            cnt_r   <= {CW{1'b0}};
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r     <= a_r >> SLICE;
          b_r     <= b_r >> SLICE;
          sum_r   <= sum_shift_s[WIDTH-1:0];
          carry_r <= slice_cout_s;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == LAST_CNT) begin
            // The slice just added holds the result MSB.
            cout_r      <= slice_cout_s;
            ovf_r       <= (a_msb_r == b_msb_r) && (slice_sum_s[SLICE-1] != a_msb_r);
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == IDLE) && rst_n;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_multicycle_cla_adder.sv
// Scoreboard bench for multicycle_cla_adder at WIDTH=32, SLICE=4.
module tb_multicycle_cla_adder;
  localparam int WIDTH = 32;
  localparam int SLICE = 4;
  localparam int NSL   = WIDTH / SLICE;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  res_t sb_q[$];
  res_t mon_r;

  multicycle_cla_adder_if #(.WIDTH(WIDTH)) bus ();

  multicycle_cla_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    res_t r;
    logic [WIDTH:0] full;
    full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return r;
  endfunction

  // Results are compared the cycle they are handed over.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        mon_r = sb_q.pop_front();
        check("sum", 64'(bus.sum), 64'(mon_r.sum));
        check("cout", 64'(bus.cout), 64'(mon_r.cout));
        check("ovf", 64'(bus.ovf), 64'(mon_r.ovf));
      end
    end
  end

  // Waits for in_ready, accepts on the next edge, then scrambles the inputs.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c, input bit push);
    int n = 0;
    bus.a = a; bus.b = b; bus.cin = c; bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.cin = 1'($urandom_range(1, 0));
    if (push) sb_q.push_back(model(a, b, c));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 50);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c, input string tag);
    int lat;
    send(a, b, c, 1'b1);
    wait_valid(lat);
    check({tag, "_latency"}, 64'(lat), 64'(NSL));
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int seen;
    logic [WIDTH-1:0] held_sum;
    logic held_cout, held_ovf;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 64'(bus.in_ready), 64'd1);

    run_op(32'h0000_0001, 32'h0000_0002, 1'b0, "small");
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "carry_all");
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "ovf_pos");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, "ovf_neg");
    run_op(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, "cin_ripple");
    for (int i = 0; i < 6; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(1, 0)), "rand");
    end

    // Backpressure with a new operand pair waiting upstream.
    bus.out_ready = 1'b0;
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b1);
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'(NSL));
    held_sum = bus.sum; held_cout = bus.cout; held_ovf = bus.ovf;
    bus.a = 32'hDEAD_BEEF; bus.b = 32'h2152_4111; bus.cin = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      check("bp_hold_sum", 64'(bus.sum), 64'(held_sum));
      check("bp_hold_cout", 64'(bus.cout), 64'(held_cout));
      check("bp_hold_ovf", 64'(bus.ovf), 64'(held_ovf));
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_drop", 64'(bus.out_valid), 64'd0);
    check("bp_idle_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    sb_q.push_back(model(32'hDEAD_BEEF, 32'h2152_4111, 1'b0));
    wait_valid(lat);
    check("bp_next_latency", 64'(lat), 64'(NSL));
    @(posedge clk);
    #1;

    // Reset on the third RUN cycle discards the operation.
    send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_sum", 64'(bus.sum), 64'd0);
    check("abort_cout", 64'(bus.cout), 64'd0);
    check("abort_in_ready_low", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < NSL + 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    run_op(32'd5, 32'd9, 1'b0, "post_abort");

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
